// File: rtl/blanket_chk.sv
// Blanket read-back checker: sweeps the whole SRAM and compares every word against EXP_DATA.
// Optional build macro BLANKET_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module blanket_chk #(
    parameter int unsigned          DATA_W   = 4,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [DATA_W-1:0]    EXP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic              rev_in,
    input  logic [DATA_W-1:0] dat_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              r_en_out,
    output logic              chk_done,
    output logic              fail,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

`ifdef BLANKET_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rev;
    logic                r_dly_en;
    logic [ADDR_W-1:0]   r_dly_addr;
    logic                r_fail;
    logic [ADDR_W:0]     r_fail_cnt;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic                r_chk_done;

    logic                w_start;
    logic                w_rd;
    logic                w_last;
    logic                w_cmp;
    logic                w_mis;

    assign w_start = (r_state == S_IDLE) && en_in;
    assign w_rd    = (r_state == S_READ) && en_in;
    assign w_last  = r_rev ? (r_addr == '0) : (r_addr == ADDR_MAX);

    // Dropping en_in kills the compare of the read still in flight.
    assign w_cmp   = r_dly_en && en_in &&
                     ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_mis   = w_cmp && (dat_in != EXP_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en_in) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (!en_in) begin
                    w_state_nxt = S_IDLE;
                end else if (STOP_ON_FAIL && w_mis) begin
                    w_state_nxt = S_DONE;
                end else if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!en_in) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!en_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address counter holds on the final address so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_rev      <= 1'b0;
            r_dly_en   <= 1'b0;
            r_dly_addr <= '0;
        end else begin
            r_dly_en <= w_rd;
            if (w_rd) begin
                r_dly_addr <= r_addr;
            end
            if (w_start) begin
                r_rev  <= rev_in;
                r_addr <= rev_in ? ADDR_MAX : '0;
            end else if (w_rd && !w_last) begin
                r_addr <= r_rev ? (r_addr - 1'b1) : (r_addr + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail      <= 1'b0;
            r_fail_cnt  <= '0;
            r_fail_addr <= '0;
        end else if (w_start) begin
            r_fail      <= 1'b0;
            r_fail_cnt  <= '0;
            r_fail_addr <= '0;
        end else if (w_mis) begin
            r_fail     <= 1'b1;
            r_fail_cnt <= r_fail_cnt + 1'b1;
            if (!r_fail) begin
                r_fail_addr <= r_dly_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_done <= 1'b0;
        end else begin
            r_chk_done <= (w_state_nxt == S_DONE);
        end
    end

    assign addr_out  = r_addr;
    assign r_en_out  = w_rd;
    assign chk_done  = r_chk_done;
    assign fail      = r_fail;
    assign fail_cnt  = r_fail_cnt;
    assign fail_addr = r_fail_addr;

endmodule
